// File: rtl/irq_pkg.sv
// ---------------------------------------------------------------------------
// irq_pkg
// Shared types and helpers for the interrupt arbiter slice.
//   arb_state_t : arbiter FSM states (IDLE, ASSERT, HOLDOFF)
//   irq_src_t   : interrupt source identifiers (SRC_KEY, SRC_ETH)
//   KEY_WORD_W  : width of a stored keyboard event {fire, dir}
//   makeKeyWord : expands a stored keyboard event into the 32-bit irq word
// ---------------------------------------------------------------------------
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    HOLDOFF
  } arb_state_t;

  typedef enum logic {
    SRC_KEY,
    SRC_ETH
  } irq_src_t;

  localparam int KEY_WORD_W = 3;

  // The processor sees the keyboard event as {29'b0, fire, dir}.
  function automatic logic [31:0] makeKeyWord(input logic fire, input logic [1:0] dir);
    return {29'b0, fire, dir};
  endfunction

endpackage

// File: rtl/irq_fifo.sv
// ---------------------------------------------------------------------------
// irq_fifo
// Small synchronous FIFO with a first-word-fall-through head. A push that
// arrives while full is still accepted when a pop happens in the same cycle.
// Ports:
//   sys_clk  : clock
//   rst_n    : synchronous active-low reset, empties the FIFO
//   i_push   : push request, accepted when not full or when popping
//   i_data   : word to push
//   i_pop    : pop request, ignored when empty
//   o_head   : oldest entry (valid while o_empty is low)
//   o_full   : FIFO holds DEPTH entries
//   o_empty  : FIFO holds no entries
// Parameters: WIDTH (entry width), DEPTH (power of two, >= 2)
// ---------------------------------------------------------------------------
module irq_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] COUNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full   = (r_count == COUNT_FULL);
  assign o_empty  = (r_count == '0);
  assign o_head   = r_mem[r_rdPtr];
  assign w_doPop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot the push needs.
  assign w_doPush = i_push & (~o_full | w_doPop);

  // Storage has no reset; occupancy is tracked by the count.
  always_ff @(posedge sys_clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// ---------------------------------------------------------------------------
// irq_arbiter
// Shares the processor's single interrupt interface between the PS/2
// keyboard and the Ethernet/SPART receivers. Each source queues events in
// its own FIFO; one event at a time is presented on its irq line with stable
// data until acknowledged (or abandoned after ACK_TIMEOUT cycles), followed
// by a GAP_CYCLES hold-off.
// Optional feature: define IRQ_ROUND_ROBIN_EN to alternate grants when both
// sources are pending; otherwise Ethernet always has priority.
// Ports:
//   sys_clk, rst_n           : clock, synchronous active-low reset
//   i_key_valid/fire/dir     : keyboard event pulse and payload
//   i_eth_valid/data         : Ethernet word pulse and payload
//   o_irq_key, o_irq_eth     : interrupt lines to the processor
//   o_irq_data               : data of the presented event (0 when idle)
//   i_irq_ack                : one-cycle processor acknowledge
//   o_ovf_key, o_ovf_eth     : sticky, an event was dropped on a full FIFO
//   o_timeout                : sticky, an event was abandoned without ack
//   i_clr_status             : clears the three sticky flags
// ---------------------------------------------------------------------------
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int KEY_DEPTH   = 4,
  parameter int ETH_DEPTH   = 4,
  parameter int GAP_CYCLES  = 8,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        i_key_valid,
  input  logic        i_key_fire,
  input  logic [1:0]  i_key_dir,
  input  logic        i_eth_valid,
  input  logic [31:0] i_eth_data,
  output logic        o_irq_key,
  output logic        o_irq_eth,
  output logic [31:0] o_irq_data,
  input  logic        i_irq_ack,
  output logic        o_ovf_key,
  output logic        o_ovf_eth,
  output logic        o_timeout,
  input  logic        i_clr_status
);

  localparam int CNT_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  arb_state_t             r_state;
  arb_state_t             w_nextState;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_irqKey;
  logic                   r_irqEth;
  logic [31:0]            r_irqData;
  logic                   r_ovfKey;
  logic                   r_ovfEth;
  logic                   r_timeout;

  logic [KEY_WORD_W-1:0]  w_keyHead;
  logic [31:0]            w_ethHead;
  logic                   w_keyFull;
  logic                   w_keyEmpty;
  logic                   w_ethFull;
  logic                   w_ethEmpty;
  logic                   w_anyReady;
  logic                   w_selEth;
  logic                   w_load;
  logic                   w_release;
  logic                   w_timeoutEvt;
  logic                   w_popKey;
  logic                   w_popEth;
  logic                   w_keyDrop;
  logic                   w_ethDrop;

  irq_fifo #(
    .WIDTH (KEY_WORD_W),
    .DEPTH (KEY_DEPTH)
  ) u_keyFifo (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .i_push  (i_key_valid),
    .i_data  ({i_key_fire, i_key_dir}),
    .i_pop   (w_popKey),
    .o_head  (w_keyHead),
    .o_full  (w_keyFull),
    .o_empty (w_keyEmpty)
  );

  irq_fifo #(
    .WIDTH (32),
    .DEPTH (ETH_DEPTH)
  ) u_ethFifo (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .i_push  (i_eth_valid),
    .i_data  (i_eth_data),
    .i_pop   (w_popEth),
    .o_head  (w_ethHead),
    .o_full  (w_ethFull),
    .o_empty (w_ethEmpty)
  );

  assign w_anyReady = ~w_keyEmpty | ~w_ethEmpty;

`ifdef IRQ_ROUND_ROBIN_EN
  irq_src_t r_lastGrant;

  // When both are pending, the source not granted last time wins.
  assign w_selEth = ~w_ethEmpty & (w_keyEmpty | (r_lastGrant == SRC_KEY));

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_lastGrant <= SRC_KEY;
    end else if (w_load) begin
      r_lastGrant <= w_selEth ? SRC_ETH : SRC_KEY;
    end
  end
`else
  // Fixed priority: Ethernet beats keyboard.
  assign w_selEth = ~w_ethEmpty;
`endif

  // State register.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; with no gap configured the hold-off state is skipped.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_anyReady) begin
          w_nextState = ASSERT;
        end
      end
      ASSERT: begin
        if (i_irq_ack || (r_cnt == ACK_LAST)) begin
          w_nextState = (GAP_CYCLES == 0) ? IDLE : HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (r_cnt == GAP_LAST) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Control outputs of the FSM. The registered irq lines identify which
  // FIFO owns the presented event, so they steer the pop.
  always_comb begin
    w_load       = 1'b0;
    w_release    = 1'b0;
    w_timeoutEvt = 1'b0;
    case (r_state)
      IDLE: begin
        w_load = w_anyReady;
      end
      ASSERT: begin
        w_release    = i_irq_ack | (r_cnt == ACK_LAST);
        w_timeoutEvt = ~i_irq_ack & (r_cnt == ACK_LAST);
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
    w_popKey  = w_release & r_irqKey;
    w_popEth  = w_release & r_irqEth;
    w_keyDrop = i_key_valid & w_keyFull & ~w_popKey;
    w_ethDrop = i_eth_valid & w_ethFull & ~w_popEth;
  end

  // Per-state cycle counter: restarts on every state change and saturates.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_nextState != r_state) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Presented event: captured from the FIFO head on grant, held until release.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_irqKey  <= 1'b0;
      r_irqEth  <= 1'b0;
      r_irqData <= '0;
    end else if (w_load) begin
      r_irqEth  <= w_selEth;
      r_irqKey  <= ~w_selEth;
      r_irqData <= w_selEth ? w_ethHead : makeKeyWord(w_keyHead[2], w_keyHead[1:0]);
    end else if (w_release) begin
      r_irqKey  <= 1'b0;
      r_irqEth  <= 1'b0;
      r_irqData <= '0;
    end
  end

  // Sticky status; a new event in the same cycle overrides the clear.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_ovfKey  <= 1'b0;
      r_ovfEth  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_ovfKey  <= w_keyDrop | (r_ovfKey & ~i_clr_status);
      r_ovfEth  <= w_ethDrop | (r_ovfEth & ~i_clr_status);
      r_timeout <= w_timeoutEvt | (r_timeout & ~i_clr_status);
    end
  end

  assign o_irq_key  = r_irqKey;
  assign o_irq_eth  = r_irqEth;
  assign o_irq_data = r_irqData;
  assign o_ovf_key  = r_ovfKey;
  assign o_ovf_eth  = r_ovfEth;
  assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_irq_arbiter.sv
// ---------------------------------------------------------------------------
// tb_irq_arbiter
// Drives directed and randomized traffic into irq_arbiter and compares every
// output each cycle against a queue-based reference model of the arbiter.
// ---------------------------------------------------------------------------
module tb_irq_arbiter;

  localparam int KEY_DEPTH   = 4;
  localparam int ETH_DEPTH   = 4;
  localparam int GAP_CYCLES  = 8;
  localparam int ACK_TIMEOUT = 1024;

  logic        sys_clk;
  logic        rst_n;
  logic        keyValid;
  logic        keyFire;
  logic [1:0]  keyDir;
  logic        ethValid;
  logic [31:0] ethData;
  logic        irqAck;
  logic        clrStatus;
  logic        irqKey;
  logic        irqEth;
  logic [31:0] irqData;
  logic        ovfKey;
  logic        ovfEth;
  logic        timeoutFlag;

  int checks = 0;
  int errors = 0;

  // Reference model state: pending events per source and the event on show.
  logic [31:0] keyQ[$];
  logic [31:0] ethQ[$];
  int          edgeNum    = 0;
  bit          busy       = 0;
  bit          busyEth    = 0;
  logic [31:0] busyData   = '0;
  int          grantEdge  = 0;
  int          readyAt    = 0;
  bit          lastWasEth = 0;
  bit          expOvfKey  = 0;
  bit          expOvfEth  = 0;
  bit          expTimeout = 0;

  irq_arbiter #(
    .KEY_DEPTH   (KEY_DEPTH),
    .ETH_DEPTH   (ETH_DEPTH),
    .GAP_CYCLES  (GAP_CYCLES),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .i_key_valid  (keyValid),
    .i_key_fire   (keyFire),
    .i_key_dir    (keyDir),
    .i_eth_valid  (ethValid),
    .i_eth_data   (ethData),
    .o_irq_key    (irqKey),
    .o_irq_eth    (irqEth),
    .o_irq_data   (irqData),
    .i_irq_ack    (irqAck),
    .o_ovf_key    (ovfKey),
    .o_ovf_eth    (ovfEth),
    .o_timeout    (timeoutFlag),
    .i_clr_status (clrStatus)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (edge %0d)", tag, observed, expected, edgeNum);
    end
  endtask

  // One clock edge of the reference model, using the inputs held at the edge.
  // Events are released by an ack or when their age reaches ACK_TIMEOUT;
  // a new grant is allowed GAP_CYCLES+1 edges after a release.
  task automatic modelStep();
    bit pickEth;
    bit keyDrop;
    bit ethDrop;
    bit tmoNow;
    edgeNum++;
    if (!rst_n) begin
      keyQ.delete();
      ethQ.delete();
      busy       = 0;
      busyEth    = 0;
      busyData   = '0;
      readyAt    = 0;
      lastWasEth = 0;
      expOvfKey  = 0;
      expOvfEth  = 0;
      expTimeout = 0;
      return;
    end
    tmoNow = 0;
    if (busy) begin
      if (irqAck || (edgeNum - grantEdge == ACK_TIMEOUT)) begin
        tmoNow = !irqAck;
        if (busyEth) void'(ethQ.pop_front());
        else         void'(keyQ.pop_front());
        busy     = 0;
        busyData = '0;
        readyAt  = edgeNum + GAP_CYCLES + 1;
      end
    end else if (edgeNum >= readyAt && (keyQ.size() > 0 || ethQ.size() > 0)) begin
      pickEth = (ethQ.size() > 0);
`ifdef IRQ_ROUND_ROBIN_EN
      if (ethQ.size() > 0 && keyQ.size() > 0) pickEth = !lastWasEth;
`endif
      lastWasEth = pickEth;
      busy       = 1;
      busyEth    = pickEth;
      grantEdge  = edgeNum;
      busyData   = pickEth ? ethQ[0] : keyQ[0];
    end
    keyDrop = 0;
    ethDrop = 0;
    if (keyValid) begin
      if (keyQ.size() < KEY_DEPTH) keyQ.push_back({29'b0, keyFire, keyDir});
      else keyDrop = 1;
    end
    if (ethValid) begin
      if (ethQ.size() < ETH_DEPTH) ethQ.push_back(ethData);
      else ethDrop = 1;
    end
    if (clrStatus) begin
      expOvfKey  = 0;
      expOvfEth  = 0;
      expTimeout = 0;
    end
    if (keyDrop) expOvfKey = 1;
    if (ethDrop) expOvfEth = 1;
    if (tmoNow)  expTimeout = 1;
  endtask

  // Advance one cycle, compare all outputs at the falling edge, drop pulses.
  task automatic applyStimulus();
    @(posedge sys_clk);
    modelStep();
    @(negedge sys_clk);
    checkOutput("irq_key",  {31'b0, irqKey},      {31'b0, busy && !busyEth});
    checkOutput("irq_eth",  {31'b0, irqEth},      {31'b0, busy && busyEth});
    checkOutput("irq_data", irqData,              busy ? busyData : 32'd0);
    checkOutput("ovf_key",  {31'b0, ovfKey},      {31'b0, expOvfKey});
    checkOutput("ovf_eth",  {31'b0, ovfEth},      {31'b0, expOvfEth});
    checkOutput("timeout",  {31'b0, timeoutFlag}, {31'b0, expTimeout});
    keyValid  = 1'b0;
    ethValid  = 1'b0;
    irqAck    = 1'b0;
    clrStatus = 1'b0;
  endtask

  task automatic randomCycle(input int validPct, input int ackPct, input int strayPct, input int clrPct);
    keyValid  = ($urandom_range(99) < validPct);
    keyFire   = 1'($urandom_range(1));
    keyDir    = 2'($urandom_range(3));
    ethValid  = ($urandom_range(99) < validPct);
    ethData   = $urandom;
    irqAck    = (irqKey || irqEth) ? ($urandom_range(99) < ackPct) : ($urandom_range(99) < strayPct);
    clrStatus = ($urandom_range(99) < clrPct);
    applyStimulus();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  initial begin
    rst_n     = 1'b0;
    keyValid  = 1'b0;
    keyFire   = 1'b0;
    keyDir    = 2'b00;
    ethValid  = 1'b0;
    ethData   = '0;
    irqAck    = 1'b0;
    clrStatus = 1'b0;
    idleCycles(3);
    rst_n = 1'b1;
    idleCycles(2);

    // Single keyboard event, fire=1 dir=10 -> data 6 two cycles later.
    keyValid = 1'b1; keyFire = 1'b1; keyDir = 2'b10;
    applyStimulus();
    applyStimulus();
    checkOutput("latency_key", {31'b0, irqKey}, 32'd1);
    checkOutput("latency_data", irqData, 32'd6);
    idleCycles(3);
    irqAck = 1'b1;
    applyStimulus();
    idleCycles(12);

    // Simultaneous keyboard and Ethernet: Ethernet goes first.
    keyValid = 1'b1; keyFire = 1'b0; keyDir = 2'b01;
    ethValid = 1'b1; ethData = 32'hCAFE0001;
    applyStimulus();
    applyStimulus();
    checkOutput("first_eth", {31'b0, irqEth}, 32'd1);
    checkOutput("first_eth_data", irqData, 32'hCAFE0001);
    for (int i = 0; i < 40; i++) begin
      irqAck = irqKey || irqEth;
      applyStimulus();
    end

    // Five keyboard pulses with no ack: fifth overflows, then drain and clear.
    for (int i = 0; i < 5; i++) begin
      keyValid = 1'b1; keyFire = 1'(i); keyDir = 2'(i + 1);
      applyStimulus();
    end
    checkOutput("ovf_after_five", {31'b0, ovfKey}, 32'd1);
    for (int i = 0; i < 60; i++) begin
      irqAck = irqKey || irqEth;
      applyStimulus();
    end
    clrStatus = 1'b1;
    applyStimulus();
    checkOutput("ovf_cleared", {31'b0, ovfKey}, 32'd0);

    // Ack timeout: first event abandoned, the next one presented after the gap.
    ethValid = 1'b1; ethData = 32'h0000BEEF;
    applyStimulus();
    keyValid = 1'b1; keyFire = 1'b1; keyDir = 2'b11;
    applyStimulus();
    idleCycles(ACK_TIMEOUT + 20);
    checkOutput("timeout_set", {31'b0, timeoutFlag}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      irqAck = irqKey || irqEth;
      applyStimulus();
    end
    clrStatus = 1'b1;
    applyStimulus();

    // Randomized traffic, moderate and then heavy with slow acks.
    for (int i = 0; i < 3000; i++) randomCycle(20, 30, 5, 2);
    for (int i = 0; i < 1500; i++) randomCycle(60, 8, 5, 1);

    // Reset while an event is on show.
    for (int i = 0; i < 40; i++) begin
      irqAck = irqKey || irqEth;
      applyStimulus();
    end
    keyValid = 1'b1; keyFire = 1'b0; keyDir = 2'b11;
    ethValid = 1'b1; ethData = 32'h12345678;
    applyStimulus();
    keyValid = 1'b1; keyDir = 2'b10;
    applyStimulus();
    begin
      int waited;
      waited = 0;
      while (!(irqKey || irqEth) && waited < 20) begin
        applyStimulus();
        waited++;
      end
      checkOutput("wait_assert", {31'b0, irqKey || irqEth}, 32'd1);
    end
    rst_n = 1'b0;
    applyStimulus();
    checkOutput("reset_irq", {30'b0, irqKey, irqEth}, 32'd0);
    rst_n = 1'b1;
    idleCycles(10);
    checkOutput("empty_after_reset", {30'b0, irqKey, irqEth}, 32'd0);

    // Final random burst after reset.
    for (int i = 0; i < 1000; i++) randomCycle(30, 25, 5, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Shares the processor's single interrupt interface between the PS/2 keyboard source and the Ethernet/SPART source.
- Each source has its own small event FIFO, so back-to-back events are not lost while the processor services an earlier interrupt.
- Selects one pending event, drives the matching irq line with stable data until the processor acknowledges, then enforces a hold-off gap.
- Sits between the keyboard/SPART front-ends and proc.

Parameters:
- KEY_DEPTH, 4: keyboard FIFO depth in entries; power of two, at least 2.
- ETH_DEPTH, 4: Ethernet FIFO depth in entries; power of two, at least 2.
- GAP_CYCLES, 8: idle cycles forced after each ack; 0 is legal.
- ACK_TIMEOUT, 1024: cycles in ASSERT without an ack before the event is abandoned.

Ports:
- sys_clk, in, 1: clock.
- rst_n, in, 1: reset; synchronous, active-low; clock sys_clk.
- key_valid, in, 1: one-cycle pulse, keyboard event done.
- key_fire, in, 1: fire bit of the keyboard event.
- key_dir, in, 2: direction of the keyboard event.
- eth_valid, in, 1: one-cycle pulse, Ethernet word received.
- eth_data, in, 32: Ethernet payload.
- irq_key, out, 1: keyboard interrupt to the processor.
- irq_eth, out, 1: Ethernet interrupt to the processor.
- irq_data, out, 32: interrupt source data.
- irq_ack, in, 1: one-cycle processor acknowledge.
- ovf_key, out, 1: sticky, keyboard event dropped.
- ovf_eth, out, 1: sticky, Ethernet event dropped.
- timeout, out, 1: sticky, an ack timeout occurred.
- clr_status, in, 1: clears all three sticky flags.

Behaviour:
- Reset: all outputs 0, both FIFOs empty, state IDLE, counters 0.
- Keyboard entry format is {29'b0, key_fire, key_dir}. Ethernet entry is eth_data unchanged.
- Push on a valid pulse when the FIFO is not full. A push when full is dropped and sets the matching ovf flag.
- Push and pop in the same cycle on a full FIFO: both happen, no overflow.
- State IDLE:
  - If either FIFO is non-empty, select a source.
  - Fixed priority: Ethernet beats keyboard.
  - Register irq_data from the selected FIFO head and the selected irq line; go to ASSERT.
- Latency: valid sampled at cycle N with the arbiter IDLE and both FIFOs empty → irq line high at N+2.
- State ASSERT:
  - Exactly one irq line is high; irq_data is held stable.
  - irq_ack high → pop the selected FIFO. irq lines go low the next cycle; go to HOLDOFF, or to IDLE if GAP_CYCLES=0.
  - If the counter reaches ACK_TIMEOUT-1 with no ack: pop and discard the event, set timeout, go to HOLDOFF.
- State HOLDOFF: count GAP_CYCLES cycles with irq lines low, then go to IDLE.
- An irq_ack outside ASSERT is ignored.
- irq_data is 0 whenever no irq line is high.
- New pushes are accepted in every state, including to the FIFO currently being serviced.
- clr_status and a new overflow in the same cycle: the overflow wins and the flag stays set.
- Counters saturate; no wrap is possible inside a state.
- Reset mid-operation: queued events are discarded and the irq lines drop on the next edge.

Optional Feature:
- Macro IRQ_ROUND_ROBIN_EN.
- Defined: when both FIFOs are non-empty, selection alternates. A last-granted register, reset to keyboard, gives the other source priority. Ethernet is therefore granted first after reset.
- Undefined: fixed priority, Ethernet over keyboard; keyboard events can starve under sustained Ethernet traffic.

Decomposition:
- irq_pkg holds:
  - arb_state_t enum: IDLE, ASSERT, HOLDOFF.
  - irq_src_t enum: SRC_KEY, SRC_ETH.
  - KEY_WORD_W = 3.
  - Helper function building the keyboard word.
- One sub-module, irq_fifo: synchronous FIFO, parameterised width and depth, with full/empty flags and first-word-fall-through head. Instantiated twice.

Test Plan:
- Single key event, key_fire=1, key_dir=2'b10 → irq_key high 2 cycles later with irq_data=32'd6. Ack → irq_key low next cycle, then 8 idle cycles.
- key_valid and eth_valid in the same cycle with eth_data=32'hCAFE0001 → irq_eth is serviced first. After its ack plus the gap, irq_key is presented.
- Five key pulses with no ack → ovf_key=1 and four entries drained in order. clr_status clears the flag.
- No ack for 1024 cycles → timeout=1, event discarded, next queued event presented after the gap.
- With IRQ_ROUND_ROBIN_EN, both FIFOs hold 3 entries → grant order eth, key, eth, key, eth, key.
- rst_n low while in ASSERT → irq lines 0 the next cycle; FIFOs are empty after release.
